nv_nvdla_attn_cbuf_rd: RTL and testbench

Read-side memory adapter between the 512-bit CBUF read port and the 128-bit Q/K/V fetch ports of the attention core. It arbitrates round-robin among the three client request ports and issues one CBUF line read per miss. It holds the most recent line in a one-entry line buffer so later hits need no CBUF access, then returns the addressed 128-bit chunk to the granted client.

---
 rtl/nv_nvdla_attn_pkg.sv | 34 +++
 rtl/nv_nvdla_attn_rr_arb3.sv | 46 ++++
 rtl/nv_nvdla_attn_cbuf_rd.sv | 181 ++++++++++++++++++
 tb/tb_nv_nvdla_attn_cbuf_rd.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_attn_pkg.sv
// nv_nvdla_attn_pkg
// Shared definitions for the attention-core CBUF read adapter:
//   - FSM state encoding (IDLE / RD_WAIT / RESP)
//   - client id encoding (Q=0, K=1, V=2) and round-robin successor helper
//   - data widths (128-bit chunk, 512-bit line, 15-bit line address)
//   - byte-address field positions for the line and chunk indices
package nv_nvdla_attn_pkg;

  localparam int CHUNK_W = 128;
  localparam int LINE_W  = 512;
  localparam int LINE_AW = 15;

  // Byte address layout: [20:6] CBUF line, [5:4] 128-bit chunk within the line
  localparam int LINE_LSB  = 6;
  localparam int LINE_MSB  = 20;
  localparam int CHUNK_LSB = 4;
  localparam int CHUNK_MSB = 5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RD_WAIT = 2'd1;
  localparam state_t ST_RESP    = 2'd2;

  typedef logic [1:0] client_t;
  localparam client_t CLIENT_Q = 2'd0;
  localparam client_t CLIENT_K = 2'd1;
  localparam client_t CLIENT_V = 2'd2;

  // Round-robin successor: q -> k -> v -> q
  function automatic client_t next_client(input client_t c);
    return (c == CLIENT_V) ? CLIENT_Q : client_t'(c + 2'd1);
  endfunction

endpackage

// File: rtl/nv_nvdla_attn_rr_arb3.sv
// nv_nvdla_attn_rr_arb3
// Three-way round-robin arbiter. The pointer names the client with highest
// priority; after a grant it moves to the client following the winner.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   req[2:0]  : request per client (bit index = client id)
//   grant_en  : high when the grant is actually consumed (pointer update)
//   gnt_vld   : at least one request present
//   gnt_id    : winning client id (meaningful only with gnt_vld)
module nv_nvdla_attn_rr_arb3
  import nv_nvdla_attn_pkg::*;
(
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic [2:0] req,
  input  logic       grant_en,
  output logic       gnt_vld,
  output client_t    gnt_id
);

  client_t ptr;
  client_t cand1;
  client_t cand2;

  always_comb begin
    cand1   = next_client(ptr);
    cand2   = next_client(cand1);
    gnt_vld = |req;
    if (req[ptr]) begin
      gnt_id = ptr;
    end else if (req[cand1]) begin
      gnt_id = cand1;
    end else begin
      gnt_id = cand2;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ptr <= CLIENT_Q;
    end else if (grant_en && gnt_vld) begin
      ptr <= next_client(gnt_id);
    end
  end

endmodule

// File: rtl/nv_nvdla_attn_cbuf_rd.sv
// nv_nvdla_attn_cbuf_rd
// Read adapter between the 512-bit CBUF read port and the 128-bit Q/K/V
// fetch ports. One request is served at a time: round-robin grant in IDLE,
// hit in the one-line buffer goes straight to RESP, a miss issues one CBUF
// line read and waits (with timeout) in RD_WAIT.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn      : clock, async active-low reset
//   {q,k,v}_valid/_addr                   : client requests (byte address)
//   {q,k,v}_data/_ready                   : one-cycle response per client
//   flush                                 : invalidate the line buffer
//   cbuf_rd_en/_addr, cbuf_rd_data/_valid : CBUF read port
//   rd_err                                : timeout flag with the aborted ready
//   hit_cnt / miss_cnt                    : saturating statistics counters
module nv_nvdla_attn_cbuf_rd
  import nv_nvdla_attn_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 q_valid,
  input  logic [31:0]          q_addr,
  output logic [CHUNK_W-1:0]   q_data,
  output logic                 q_ready,
  input  logic                 k_valid,
  input  logic [31:0]          k_addr,
  output logic [CHUNK_W-1:0]   k_data,
  output logic                 k_ready,
  input  logic                 v_valid,
  input  logic [31:0]          v_addr,
  output logic [CHUNK_W-1:0]   v_data,
  output logic                 v_ready,
  input  logic                 flush,
  output logic                 cbuf_rd_en,
  output logic [LINE_AW-1:0]   cbuf_rd_addr,
  input  logic [LINE_W-1:0]    cbuf_rd_data,
  input  logic                 cbuf_rd_valid,
  output logic                 rd_err,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt
);

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  state_t               state;
  client_t              cl_id;
  logic [1:0]           chunk_q;
  logic                 err_q;
  logic [7:0]           tmo_cnt;
  logic [LINE_W-1:0]    buf_data;
  logic                 buf_valid;
  logic [LINE_AW-1:0]   buf_tag;

  logic                 gnt_vld;
  client_t              gnt_id;
  logic [LINE_AW-1:0]   sel_line;
  logic [1:0]           sel_chunk;
  logic                 hit;
  logic [CHUNK_W-1:0]   resp_data;
  logic                 resp;

  // Address bits outside the line/chunk fields are don't-care
  logic unused_addr_bits;
  assign unused_addr_bits = ^{q_addr[31:21], q_addr[3:0],
                              k_addr[31:21], k_addr[3:0],
                              v_addr[31:21], v_addr[3:0]};

  nv_nvdla_attn_rr_arb3 u_arb (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .req             ({v_valid, k_valid, q_valid}),
    .grant_en        (state == ST_IDLE),
    .gnt_vld         (gnt_vld),
    .gnt_id          (gnt_id)
  );

  always_comb begin
    case (gnt_id)
      CLIENT_K: begin
        sel_line  = k_addr[LINE_MSB:LINE_LSB];
        sel_chunk = k_addr[CHUNK_MSB:CHUNK_LSB];
      end
      CLIENT_V: begin
        sel_line  = v_addr[LINE_MSB:LINE_LSB];
        sel_chunk = v_addr[CHUNK_MSB:CHUNK_LSB];
      end
      default: begin
        sel_line  = q_addr[LINE_MSB:LINE_LSB];
        sel_chunk = q_addr[CHUNK_MSB:CHUNK_LSB];
      end
    endcase
    hit = buf_valid && (buf_tag == sel_line);
  end

  // cbuf_rd_addr holds the missed line for the whole read, so it doubles as
  // the tag source at capture. flush is applied last so it overrides a
  // simultaneous capture while the captured data is still returned.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state        <= ST_IDLE;
      cl_id        <= CLIENT_Q;
      chunk_q      <= 2'd0;
      err_q        <= 1'b0;
      tmo_cnt      <= 8'd0;
      buf_data     <= '0;
      buf_valid    <= 1'b0;
      buf_tag      <= '0;
      cbuf_rd_en   <= 1'b0;
      cbuf_rd_addr <= '0;
      hit_cnt      <= 16'd0;
      miss_cnt     <= 16'd0;
    end else begin
      cbuf_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            cl_id   <= gnt_id;
            chunk_q <= sel_chunk;
            err_q   <= 1'b0;
            if (hit) begin
              state   <= ST_RESP;
              hit_cnt <= (hit_cnt == 16'hFFFF) ? hit_cnt : hit_cnt + 16'd1;
            end else begin
              state        <= ST_RD_WAIT;
              cbuf_rd_en   <= 1'b1;
              cbuf_rd_addr <= sel_line;
              tmo_cnt      <= 8'd0;
              miss_cnt     <= (miss_cnt == 16'hFFFF) ? miss_cnt : miss_cnt + 16'd1;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cbuf_rd_valid) begin
            buf_data  <= cbuf_rd_data;
            buf_tag   <= cbuf_rd_addr;
            buf_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (tmo_cnt == TMO) begin
            err_q     <= 1'b1;
            buf_valid <= 1'b0;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (flush) begin
        buf_valid <= 1'b0;
      end
    end
  end

  // Response data is zero on an aborted read; buffer contents stay intact
  always_comb begin
    case (chunk_q)
      2'd1:    resp_data = buf_data[2*CHUNK_W-1:CHUNK_W];
      2'd2:    resp_data = buf_data[3*CHUNK_W-1:2*CHUNK_W];
      2'd3:    resp_data = buf_data[4*CHUNK_W-1:3*CHUNK_W];
      default: resp_data = buf_data[CHUNK_W-1:0];
    endcase
    if (err_q) begin
      resp_data = '0;
    end
  end

  assign resp    = (state == ST_RESP);
  assign q_ready = resp && (cl_id == CLIENT_Q);
  assign k_ready = resp && (cl_id == CLIENT_K);
  assign v_ready = resp && (cl_id == CLIENT_V);
  assign q_data  = q_ready ? resp_data : '0;
  assign k_data  = k_ready ? resp_data : '0;
  assign v_data  = v_ready ? resp_data : '0;
  assign rd_err  = resp && err_q;

endmodule

// File: tb/tb_nv_nvdla_attn_cbuf_rd.sv
// tb_nv_nvdla_attn_cbuf_rd
// Directed testbench for nv_nvdla_attn_cbuf_rd (TIMEOUT=4). Inputs change
// and outputs are sampled 1ns after each rising edge.
module tb_nv_nvdla_attn_cbuf_rd;

  logic         nvdla_core_clk = 1'b0;
  logic         nvdla_core_rstn;
  logic         q_valid, k_valid, v_valid;
  logic [31:0]  q_addr, k_addr, v_addr;
  logic [127:0] q_data, k_data, v_data;
  logic         q_ready, k_ready, v_ready;
  logic         flush;
  logic         cbuf_rd_en;
  logic [14:0]  cbuf_rd_addr;
  logic [511:0] cbuf_rd_data;
  logic         cbuf_rd_valid;
  logic         rd_err;
  logic [15:0]  hit_cnt, miss_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  nv_nvdla_attn_cbuf_rd #(.TIMEOUT(4)) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .q_valid         (q_valid),
    .q_addr          (q_addr),
    .q_data          (q_data),
    .q_ready         (q_ready),
    .k_valid         (k_valid),
    .k_addr          (k_addr),
    .k_data          (k_data),
    .k_ready         (k_ready),
    .v_valid         (v_valid),
    .v_addr          (v_addr),
    .v_data          (v_data),
    .v_ready         (v_ready),
    .flush           (flush),
    .cbuf_rd_en      (cbuf_rd_en),
    .cbuf_rd_addr    (cbuf_rd_addr),
    .cbuf_rd_data    (cbuf_rd_data),
    .cbuf_rd_valid   (cbuf_rd_valid),
    .rd_err          (rd_err),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
  );

  // Word i of line n is {16'hA000+n, i}
  function automatic logic [511:0] make_line(input int n);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) begin
      l[i*32 +: 32] = {16'hA000 + 16'(n), 16'(i)};
    end
    return l;
  endfunction

  function automatic logic [127:0] chunk_of(input logic [511:0] l, input int c);
    return l[c*128 +: 128];
  endfunction

  task automatic tick;
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic do_reset;
    nvdla_core_rstn = 1'b0;
    q_valid = 1'b0; k_valid = 1'b0; v_valid = 1'b0;
    q_addr = 32'h0; k_addr = 32'h0; v_addr = 32'h0;
    flush = 1'b0; cbuf_rd_valid = 1'b0; cbuf_rd_data = '0;
    repeat (2) @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;
  endtask

  task automatic test_reset;
    checks++;
    if ({q_ready, k_ready, v_ready, rd_err, cbuf_rd_en} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000", {q_ready, k_ready, v_ready, rd_err, cbuf_rd_en});
    end
    checks++;
    if ({q_data, k_data, v_data} !== 384'h0 || cbuf_rd_addr !== 15'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got addr %h, data nonzero=%0b", cbuf_rd_addr, |{q_data, k_data, v_data});
    end
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_counters: got hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_miss_then_hit;
    q_valid = 1'b1; q_addr = 32'h40;
    tick;
    checks++;
    if (cbuf_rd_en !== 1'b1 || cbuf_rd_addr !== 15'd1 || q_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL miss_issue: got en=%b addr=%0d rdy=%b expected 1/1/0", cbuf_rd_en, cbuf_rd_addr, q_ready);
    end
    tick;
    checks++;
    if (cbuf_rd_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL miss_strobe_len: got en=%b in cycle 2 expected 0", cbuf_rd_en);
    end
    cbuf_rd_valid = 1'b1; cbuf_rd_data = make_line(1);
    tick;
    cbuf_rd_valid = 1'b0;
    checks++;
    if (q_ready !== 1'b1 || q_data !== 128'hA0010003_A0010002_A0010001_A0010000 || rd_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL miss_resp: got rdy=%b data=%h err=%b", q_ready, q_data, rd_err);
    end
    checks++;
    if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL miss_cnt: got miss=%0d hit=%0d expected 1/0", miss_cnt, hit_cnt);
    end
    q_valid = 1'b0;
    tick;
    checks++;
    if (q_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_pulse: got q_ready=%b after response expected 0", q_ready);
    end
    k_valid = 1'b1; k_addr = 32'h70;
    tick;
    checks++;
    if (k_ready !== 1'b1 || q_ready !== 1'b0 || cbuf_rd_en !== 1'b0 ||
        k_data !== 128'hA001000F_A001000E_A001000D_A001000C) begin
      failures++;
      $display("[TB] FAIL hit_resp: got rdy=%b en=%b data=%h", k_ready, cbuf_rd_en, k_data);
    end
    checks++;
    if (hit_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL hit_cnt: got %0d expected 1", hit_cnt);
    end
    k_valid = 1'b0;
    tick;
  endtask

  task automatic test_rr_order;
    int lines [3] = '{2, 3, 4};
    int chunks[3] = '{0, 1, 2};
    logic [127:0] got;
    do_reset;
    q_addr = 32'h80; k_addr = 32'hD0; v_addr = 32'h120;
    q_valid = 1'b1; k_valid = 1'b1; v_valid = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cbuf_rd_en !== 1'b1 || cbuf_rd_addr !== 15'(lines[i])) begin
        failures++;
        $display("[TB] FAIL rr_issue%0d: got en=%b addr=%0d expected 1/%0d", i, cbuf_rd_en, cbuf_rd_addr, lines[i]);
      end
      tick;
      cbuf_rd_valid = 1'b1; cbuf_rd_data = make_line(lines[i]);
      tick;
      cbuf_rd_valid = 1'b0;
      case (i)
        0:       got = q_data;
        1:       got = k_data;
        default: got = v_data;
      endcase
      checks++;
      if ({v_ready, k_ready, q_ready} !== 3'(1 << i) || got !== chunk_of(make_line(lines[i]), chunks[i])) begin
        failures++;
        $display("[TB] FAIL rr_resp%0d: got readys=%b data=%h", i, {v_ready, k_ready, q_ready}, got);
      end
      case (i)
        0:       q_valid = 1'b0;
        1:       k_valid = 1'b0;
        default: v_valid = 1'b0;
      endcase
      tick;
      if (i < 2) tick;
    end
    // Pointer now favours q; both requests hit line 4
    q_addr = 32'h100; v_addr = 32'h130;
    q_valid = 1'b1; v_valid = 1'b1;
    tick;
    checks++;
    if ({v_ready, k_ready, q_ready} !== 3'b001 || cbuf_rd_en !== 1'b0 || q_data !== chunk_of(make_line(4), 0)) begin
      failures++;
      $display("[TB] FAIL rr_qv_first: got readys=%b en=%b data=%h", {v_ready, k_ready, q_ready}, cbuf_rd_en, q_data);
    end
    q_valid = 1'b0;
    tick;
    tick;
    checks++;
    if ({v_ready, k_ready, q_ready} !== 3'b100 || v_data !== chunk_of(make_line(4), 3)) begin
      failures++;
      $display("[TB] FAIL rr_qv_second: got readys=%b data=%h", {v_ready, k_ready, q_ready}, v_data);
    end
    v_valid = 1'b0;
    tick;
    checks++;
    if (hit_cnt !== 16'd2 || miss_cnt !== 16'd3) begin
      failures++;
      $display("[TB] FAIL rr_counters: got hit=%0d miss=%0d expected 2/3", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_flush_capture;
    q_valid = 1'b1; q_addr = 32'h80;
    tick;
    tick;
    cbuf_rd_valid = 1'b1; cbuf_rd_data = make_line(2); flush = 1'b1;
    tick;
    cbuf_rd_valid = 1'b0; flush = 1'b0;
    checks++;
    if (q_ready !== 1'b1 || q_data !== chunk_of(make_line(2), 0)) begin
      failures++;
      $display("[TB] FAIL flush_resp: got rdy=%b data=%h", q_ready, q_data);
    end
    q_valid = 1'b0;
    tick;
    q_valid = 1'b1; q_addr = 32'h90;
    tick;
    checks++;
    if (cbuf_rd_en !== 1'b1 || cbuf_rd_addr !== 15'd2 || miss_cnt !== 16'd5) begin
      failures++;
      $display("[TB] FAIL flush_remiss: got en=%b addr=%0d miss=%0d expected 1/2/5", cbuf_rd_en, cbuf_rd_addr, miss_cnt);
    end
    tick;
    cbuf_rd_valid = 1'b1; cbuf_rd_data = make_line(2);
    tick;
    cbuf_rd_valid = 1'b0;
    checks++;
    if (q_ready !== 1'b1 || q_data !== chunk_of(make_line(2), 1)) begin
      failures++;
      $display("[TB] FAIL flush_refill: got rdy=%b data=%h", q_ready, q_data);
    end
    q_valid = 1'b0;
    tick;
  endtask

  task automatic test_stray_valid;
    cbuf_rd_valid = 1'b1; cbuf_rd_data = make_line(9);
    tick;
    cbuf_rd_valid = 1'b0;
    tick;
    k_valid = 1'b1; k_addr = 32'hA0;
    tick;
    checks++;
    if (k_ready !== 1'b1 || cbuf_rd_en !== 1'b0 || k_data !== chunk_of(make_line(2), 2)) begin
      failures++;
      $display("[TB] FAIL stray_ignored: got rdy=%b en=%b data=%h", k_ready, cbuf_rd_en, k_data);
    end
    k_valid = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    v_valid = 1'b1; v_addr = 32'h150;
    tick;
    checks++;
    if (cbuf_rd_en !== 1'b1 || cbuf_rd_addr !== 15'd5) begin
      failures++;
      $display("[TB] FAIL tmo_issue: got en=%b addr=%0d expected 1/5", cbuf_rd_en, cbuf_rd_addr);
    end
    for (int c = 2; c <= 5; c++) begin
      tick;
      checks++;
      if ({q_ready, k_ready, v_ready, rd_err} !== 4'b0) begin
        failures++;
        $display("[TB] FAIL tmo_early_c%0d: got readys/err=%b expected 0000", c, {q_ready, k_ready, v_ready, rd_err});
      end
    end
    tick;
    checks++;
    if (v_ready !== 1'b1 || rd_err !== 1'b1 || v_data !== 128'h0) begin
      failures++;
      $display("[TB] FAIL tmo_resp: got rdy=%b err=%b data=%h expected 1/1/0", v_ready, rd_err, v_data);
    end
    v_valid = 1'b0;
    tick;
    checks++;
    if (rd_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_err_pulse: got rd_err=%b expected 0", rd_err);
    end
    v_valid = 1'b1;
    tick;
    checks++;
    if (cbuf_rd_en !== 1'b1 || cbuf_rd_addr !== 15'd5) begin
      failures++;
      $display("[TB] FAIL tmo_remiss: got en=%b addr=%0d expected 1/5", cbuf_rd_en, cbuf_rd_addr);
    end
    tick;
    cbuf_rd_valid = 1'b1; cbuf_rd_data = make_line(5);
    tick;
    cbuf_rd_valid = 1'b0;
    checks++;
    if (v_ready !== 1'b1 || rd_err !== 1'b0 || v_data !== chunk_of(make_line(5), 1)) begin
      failures++;
      $display("[TB] FAIL tmo_recover: got rdy=%b err=%b data=%h", v_ready, rd_err, v_data);
    end
    v_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_read;
    q_valid = 1'b1; q_addr = 32'h180;
    tick;
    tick;
    nvdla_core_rstn = 1'b0;
    q_valid = 1'b0;
    #2;
    checks++;
    if (cbuf_rd_addr !== 15'd0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got addr=%0d hit=%0d miss=%0d expected 0", cbuf_rd_addr, hit_cnt, miss_cnt);
    end
    tick;
    tick;
    nvdla_core_rstn = 1'b1;
    tick;
    cbuf_rd_valid = 1'b1; cbuf_rd_data = make_line(6);
    tick;
    cbuf_rd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({q_ready, k_ready, v_ready, rd_err, cbuf_rd_en} !== 5'b0 || q_data !== 128'h0) begin
        failures++;
        $display("[TB] FAIL late_valid_c%0d: got strobes=%b", c, {q_ready, k_ready, v_ready, rd_err, cbuf_rd_en});
      end
      tick;
    end
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL late_valid_cnt: got hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt);
    end
    q_valid = 1'b1;
    tick;
    checks++;
    if (cbuf_rd_en !== 1'b1 || cbuf_rd_addr !== 15'd6) begin
      failures++;
      $display("[TB] FAIL late_valid_nofill: got en=%b addr=%0d expected 1/6", cbuf_rd_en, cbuf_rd_addr);
    end
    q_valid = 1'b0;
    tick;
    cbuf_rd_valid = 1'b1;
    tick;
    cbuf_rd_valid = 1'b0;
    tick;
  endtask

  initial begin
    do_reset;
    test_reset;
    test_miss_then_hit;
    test_rr_order;
    test_flush_capture;
    test_stray_valid;
    test_timeout;
    test_reset_mid_read;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
